// File: rtl/apb_slv_switch.sv
// APB switch: one upstream master routed to NSLV downstream slaves by address map.
// Define APB_SLV_SWITCH_TIMEOUT_EN to force an error response when a slave stalls too long.
`timescale 1ns/1ps

package apb_slv_switch_pkg;

   typedef struct packed {
      logic [31:0] paddr;
      logic        psel;
      logic        penable;
      logic        pwrite;
      logic [31:0] pwdata;
      logic [3:0]  pstrb;
      logic [2:0]  pprot;
   } apb_in_type;

   typedef struct packed {
      logic        pready;
      logic [31:0] prdata;
      logic        pslverr;
   } apb_out_type;

   typedef struct packed {
      logic [63:0] addr_start;
      logic [63:0] addr_end;
   } mapinfo_type;

   // 4 KB windows: UART, PRCI, DMI, GPIO, DDR mgmt, PCIE, PnP
   localparam mapinfo_type [0:6] BUS1_MAP = {
      mapinfo_type'{64'h0000_0000_0001_0000, 64'h0000_0000_0001_1000},
      mapinfo_type'{64'h0000_0000_0001_2000, 64'h0000_0000_0001_3000},
      mapinfo_type'{64'h0000_0000_0001_E000, 64'h0000_0000_0001_F000},
      mapinfo_type'{64'h0000_0000_0006_0000, 64'h0000_0000_0006_1000},
      mapinfo_type'{64'h0000_0000_000C_0000, 64'h0000_0000_000C_1000},
      mapinfo_type'{64'h0000_0000_000C_1000, 64'h0000_0000_000C_2000},
      mapinfo_type'{64'h0000_0000_000F_F000, 64'h0000_0000_0010_0000}
   };

endpackage

module apb_slv_switch
   import apb_slv_switch_pkg::*;
#(
   parameter int                      NSLV           = 7,
   parameter mapinfo_type [0:NSLV-1]  MAP            = BUS1_MAP,
   parameter int                      TIMEOUT_CYCLES = 1023
) (
   input  logic                        i_clk,
   input  logic                        i_nrst,
   input  apb_in_type                  i_apbi,
   output apb_out_type                 o_apbo,
   output apb_in_type                  o_apbi [0:NSLV-1],
   input  apb_out_type                 i_apbo [0:NSLV-1],
   output logic [$clog2(NSLV+1)-1:0]   o_sel_idx
);

   localparam int            SW       = $clog2(NSLV+1);
   localparam logic [SW-1:0] IDX_NONE = SW'(NSLV);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t        r_state,  w_state_nxt;
   logic [SW-1:0] r_sel,    w_sel_nxt;
   logic [31:0]   r_paddr,  w_paddr_nxt;
   logic          r_pwrite, w_pwrite_nxt;
   logic [31:0]   r_pwdata, w_pwdata_nxt;
   logic [3:0]    r_pstrb,  w_pstrb_nxt;
   logic [2:0]    r_pprot,  w_pprot_nxt;
   logic [31:0]   r_rdata,  w_rdata_nxt;
   logic          r_err,    w_err_nxt;

   logic          w_hit;
   logic          w_match;
   logic [SW-1:0] w_hit_idx;
   apb_out_type   w_slv_rsp;
   logic          w_unused_penable;

   apb_out_type   r_apbo,    w_apbo_nxt;
   apb_in_type    r_apbi     [0:NSLV-1];
   apb_in_type    w_apbi_nxt [0:NSLV-1];
   logic [SW-1:0] r_sel_idx, w_sel_idx_nxt;

`ifdef APB_SLV_SWITCH_TIMEOUT_EN
   localparam int            CW        = $clog2(TIMEOUT_CYCLES+1);
   localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;

   assign w_cnt_inc = r_cnt + CW'(1);
`endif

   // Upstream penable carries no information the FSM needs; psel alone starts a transfer.
   assign w_unused_penable = i_apbi.penable;

   // Address decode; scanning downward leaves the lowest matching index on overlap.
   always_comb begin
      w_hit     = 1'b0;
      w_match   = 1'b0;
      w_hit_idx = IDX_NONE;
      for (int k = NSLV - 1; k >= 0; k--) begin
         w_match   = ({32'h0, i_apbi.paddr} >= MAP[k].addr_start) &&
                     ({32'h0, i_apbi.paddr} <  MAP[k].addr_end);
         w_hit_idx = w_match ? SW'(k) : w_hit_idx;
         w_hit     = w_hit | w_match;
      end
   end

   // Response mux from the currently selected slave.
   always_comb begin
      w_slv_rsp = '0;
      for (int k = 0; k < NSLV; k++) begin
         w_slv_rsp = (r_sel == SW'(k)) ? i_apbo[k] : w_slv_rsp;
      end
   end

   // Transfer FSM next-state and latched-field updates.
   always_comb begin
      w_state_nxt  = r_state;
      w_sel_nxt    = r_sel;
      w_paddr_nxt  = r_paddr;
      w_pwrite_nxt = r_pwrite;
      w_pwdata_nxt = r_pwdata;
      w_pstrb_nxt  = r_pstrb;
      w_pprot_nxt  = r_pprot;
      w_rdata_nxt  = r_rdata;
      w_err_nxt    = r_err;
`ifdef APB_SLV_SWITCH_TIMEOUT_EN
      w_cnt_nxt    = r_cnt;
`endif
      case (r_state)
         ST_IDLE: begin
            if (i_apbi.psel) begin
               w_paddr_nxt  = i_apbi.paddr;
               w_pwrite_nxt = i_apbi.pwrite;
               w_pwdata_nxt = i_apbi.pwdata;
               w_pstrb_nxt  = i_apbi.pstrb;
               w_pprot_nxt  = i_apbi.pprot;
               if (w_hit) begin
                  w_state_nxt = ST_SETUP;
                  w_sel_nxt   = w_hit_idx;
               end else begin
                  w_state_nxt = ST_RESP;
                  w_sel_nxt   = IDX_NONE;
                  w_err_nxt   = 1'b1;
                  w_rdata_nxt = 32'h0;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SETUP: begin
            w_state_nxt = ST_ACCESS;
`ifdef APB_SLV_SWITCH_TIMEOUT_EN
            w_cnt_nxt   = '0;
`endif
         end
         ST_ACCESS: begin
            // A slave pready in the limit cycle takes priority over the timeout.
            if (w_slv_rsp.pready) begin
               w_state_nxt = ST_RESP;
               w_rdata_nxt = w_slv_rsp.prdata;
               w_err_nxt   = w_slv_rsp.pslverr;
            end
`ifdef APB_SLV_SWITCH_TIMEOUT_EN
            else if (w_cnt_inc == CNT_LIMIT) begin
               w_state_nxt = ST_RESP;
               w_rdata_nxt = 32'hFFFF_FFFF;
               w_err_nxt   = 1'b1;
            end else begin
               w_cnt_nxt   = w_cnt_inc;
            end
`else
            else begin
               w_state_nxt = ST_ACCESS;
            end
`endif
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
            w_sel_nxt   = IDX_NONE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_sel_nxt   = IDX_NONE;
         end
      endcase
   end

   // Output values for the coming cycle, derived from the next state so outputs stay registered.
   always_comb begin
      w_apbo_nxt    = '0;
      w_sel_idx_nxt = IDX_NONE;
      if (w_state_nxt == ST_RESP) begin
         w_apbo_nxt.pready  = 1'b1;
         w_apbo_nxt.prdata  = w_rdata_nxt;
         w_apbo_nxt.pslverr = w_err_nxt;
      end else begin
         w_apbo_nxt = '0;
      end
      if ((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS)) begin
         w_sel_idx_nxt = w_sel_nxt;
      end else begin
         w_sel_idx_nxt = IDX_NONE;
      end
      for (int k = 0; k < NSLV; k++) begin
         w_apbi_nxt[k]         = '0;
         w_apbi_nxt[k].paddr   = w_paddr_nxt;
         w_apbi_nxt[k].pwrite  = w_pwrite_nxt;
         w_apbi_nxt[k].pwdata  = w_pwdata_nxt;
         w_apbi_nxt[k].pstrb   = w_pstrb_nxt;
         w_apbi_nxt[k].pprot   = w_pprot_nxt;
         w_apbi_nxt[k].psel    = (w_sel_idx_nxt == SW'(k));
         w_apbi_nxt[k].penable = (w_sel_idx_nxt == SW'(k)) && (w_state_nxt == ST_ACCESS);
      end
   end

   // FSM state and latched transfer fields.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_state  <= ST_IDLE;
         r_sel    <= IDX_NONE;
         r_paddr  <= 32'h0;
         r_pwrite <= 1'b0;
         r_pwdata <= 32'h0;
         r_pstrb  <= 4'h0;
         r_pprot  <= 3'h0;
         r_rdata  <= 32'h0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_sel    <= w_sel_nxt;
         r_paddr  <= w_paddr_nxt;
         r_pwrite <= w_pwrite_nxt;
         r_pwdata <= w_pwdata_nxt;
         r_pstrb  <= w_pstrb_nxt;
         r_pprot  <= w_pprot_nxt;
         r_rdata  <= w_rdata_nxt;
         r_err    <= w_err_nxt;
      end
   end

`ifdef APB_SLV_SWITCH_TIMEOUT_EN
   // ACCESS-phase wait counter.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end
`endif

   // Output registers.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_apbo    <= '0;
         r_sel_idx <= IDX_NONE;
         for (int k = 0; k < NSLV; k++) begin
            r_apbi[k] <= '0;
         end
      end else begin
         r_apbo    <= w_apbo_nxt;
         r_sel_idx <= w_sel_idx_nxt;
         for (int k = 0; k < NSLV; k++) begin
            r_apbi[k] <= w_apbi_nxt[k];
         end
      end
   end

   assign o_apbo    = r_apbo;
   assign o_apbi    = r_apbi;
   assign o_sel_idx = r_sel_idx;

endmodule

// File: tb/tb_apb_slv_switch.sv
// Randomized scoreboard bench for apb_slv_switch with an address-map reference model and slave models.
`timescale 1ns/1ps

module tb_apb_slv_switch;
   import apb_slv_switch_pkg::*;

   localparam int NSLV       = 7;
   localparam int TB_TIMEOUT = 15;
   localparam int SW         = $clog2(NSLV+1);
   localparam int BUDGET     = 200;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          issue;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   apb_in_type    up_req;
   apb_out_type   up_rsp;
   apb_in_type    dn_req [0:NSLV-1];
   apb_out_type   dn_rsp [0:NSLV-1];
   logic [SW-1:0] sel_idx;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   int          exp_slave = -1;
   logic [31:0] exp_addr, exp_wdata;
   logic        exp_wr;
   logic [3:0]  exp_strb;
   logic [2:0]  exp_prot;

   int          swait  [NSLV];
   logic [31:0] srdata [NSLV];
   logic        serr   [NSLV];
   int          scnt   [NSLV];
   logic [31:0] map_base [NSLV] = '{32'h0001_0000, 32'h0001_2000, 32'h0001_E000, 32'h0006_0000,
                                    32'h000C_0000, 32'h000C_1000, 32'h000F_F000};

   apb_slv_switch #(.NSLV(NSLV), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .i_clk     (clk),
      .i_nrst    (rst_n),
      .i_apbi    (up_req),
      .o_apbo    (up_rsp),
      .o_apbi    (dn_req),
      .i_apbo    (dn_rsp),
      .o_sel_idx (sel_idx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference decode: every slave owns a 4 KB window starting at its base.
   function automatic int ref_decode(input logic [31:0] a);
      for (int i = 0; i < NSLV; i++) begin
         if (a >= map_base[i] && (a - map_base[i]) < 32'd4096) return i;
      end
      return -1;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      logic nz;
      nz = 1'b0;
      for (int k = 0; k < NSLV; k++) nz = nz | (dn_req[k] != '0);
      check({tag, "_up_rsp"}, up_rsp, 0);
      check({tag, "_dn_req"}, nz, 0);
      check({tag, "_sel_idx"}, sel_idx, NSLV);
   endtask

   // Slave models: the selected slave answers after its wait count; others emit noise.
   initial begin
      for (int k = 0; k < NSLV; k++) begin
         dn_rsp[k] = '0; scnt[k] = 0; swait[k] = 0; srdata[k] = 32'h0; serr[k] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < NSLV; k++) begin
            if (dn_req[k].psel && dn_req[k].penable) begin
               if (scnt[k] >= swait[k]) begin
                  dn_rsp[k].pready  = 1'b1;
                  dn_rsp[k].prdata  = srdata[k];
                  dn_rsp[k].pslverr = serr[k];
               end else begin
                  dn_rsp[k].pready  = 1'b0;
                  dn_rsp[k].prdata  = $urandom;
                  dn_rsp[k].pslverr = 1'($urandom_range(0, 1));
               end
               scnt[k]++;
            end else begin
               scnt[k] = 0;
               dn_rsp[k].pready  = 1'($urandom_range(0, 1));
               dn_rsp[k].prdata  = $urandom;
               dn_rsp[k].pslverr = 1'($urandom_range(0, 1));
            end
         end
      end
   end

   // Upstream monitor: every pready pops one expected response.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && up_rsp.pready) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_pready actual=1 required=0 (t=%0t)", $time);
            end else begin
               mon_e = sb.pop_front();
               check("rsp_prdata", up_rsp.prdata, mon_e.rdata);
               check("rsp_pslverr", up_rsp.pslverr, mon_e.err);
               check("rsp_latency", cyc - mon_e.issue, mon_e.lat);
            end
         end
      end
   end

   // Downstream watcher: only the expected slave is selected, with the exact request fields.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            for (int k = 0; k < NSLV; k++) begin
               if (dn_req[k].psel) begin
                  check("psel_slave", k, exp_slave);
                  if (!dn_req[k].penable) begin
                     check("setup_addr_ctl", {dn_req[k].paddr, dn_req[k].pwrite, dn_req[k].pprot},
                           {exp_addr, exp_wr, exp_prot});
                     check("setup_data_strb", {dn_req[k].pwdata, dn_req[k].pstrb}, {exp_wdata, exp_strb});
                  end else begin
                     check("access_sel_idx", sel_idx, k);
                  end
               end
            end
         end
      end
   end

   task automatic drive_req(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot, input int k);
      exp_slave = k; exp_addr = addr; exp_wr = wr; exp_wdata = wdata; exp_strb = strb; exp_prot = prot;
      up_req.paddr = addr; up_req.pwrite = wr; up_req.pwdata = wdata;
      up_req.pstrb = strb; up_req.pprot = prot; up_req.psel = 1'b1; up_req.penable = 1'b0;
   endtask

   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot, input int waits,
                       input logic [31:0] rdat, input logic serr_in);
      int   k;
      exp_t e;
      bit   done;
      k = ref_decode(addr);
      if (k >= 0) begin
         swait[k] = waits; srdata[k] = rdat; serr[k] = serr_in;
      end
      if (k < 0) begin
         e.rdata = 32'h0; e.err = 1'b1; e.lat = 1;
      end
`ifdef APB_SLV_SWITCH_TIMEOUT_EN
      else if (waits >= TB_TIMEOUT) begin
         e.rdata = 32'hFFFF_FFFF; e.err = 1'b1; e.lat = TB_TIMEOUT + 2;
      end
`endif
      else begin
         e.rdata = rdat; e.err = serr_in; e.lat = 3 + waits;
      end
      @(posedge clk); #1;
      drive_req(addr, wr, wdata, strb, prot, k);
      e.issue = cyc;
      sb.push_back(e);
      done = 1'b0;
      for (int n = 0; n < BUDGET && !done; n++) begin
         @(negedge clk);
         if (up_rsp.pready) done = 1'b1;
         else begin
            @(posedge clk); #1;
            up_req.penable = 1'b1;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL xfer_wait addr=%08h actual=no_pready required=pready", addr);
      end
      exp_slave = -1;
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1;
      up_req.psel = 1'b0; up_req.penable = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   // Slave that never answers: confirm the switch keeps waiting, then pulse reset mid-ACCESS.
   task automatic hang_and_reset(input logic [31:0] addr, input int hold);
      int k;
      bit seen, got;
      k = ref_decode(addr);
      swait[k] = 1000000; srdata[k] = $urandom; serr[k] = 1'b0;
      @(posedge clk); #1;
      drive_req(addr, 1'b0, 32'h1234_5678, 4'hF, 3'd1, k);
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (dn_req[k].penable) seen = 1'b1;
         else begin
            @(posedge clk); #1;
            up_req.penable = 1'b1;
         end
      end
      check("hang_access_reached", seen, 1);
      got = 1'b0;
      repeat (hold) begin
         @(negedge clk);
         if (up_rsp.pready) got = 1'b1;
      end
      check("hang_no_response", got, 0);
      rst_n = 1'b0;
      up_req = '0;
      exp_slave = -1;
      #1;
      check_reset_outputs("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a;
      int          k;
      up_req = '0;
      rst_n  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;

      xfer(32'h0001_2004, 1'b0, 32'h0, 4'h0, 3'd0, 0, 32'hCAFE_0001, 1'b0);
      xfer(32'h0006_0010, 1'b1, 32'h5A5A_5A5A, 4'hF, 3'd2, 4, $urandom, 1'b0);
      xfer(32'h0002_0000, 1'b0, 32'h0, 4'h0, 3'd0, 0, 32'h0, 1'b0);
      xfer(32'h0001_0FFC, 1'b0, 32'h0, 4'h0, 3'd0, 1, 32'h0BAD_F00D, 1'b0);
      xfer(32'h0001_1000, 1'b1, 32'h0000_1111, 4'h3, 3'd0, 0, 32'h0, 1'b0);
      xfer(32'h000C_1008, 1'b1, 32'hDEAD_BEEF, 4'h5, 3'd7, 2, 32'h7777_0000, 1'b1);
      idle(2);
`ifdef APB_SLV_SWITCH_TIMEOUT_EN
      xfer(32'h0001_E000, 1'b0, 32'h0, 4'h0, 3'd0, TB_TIMEOUT - 1, 32'h1357_9BDF, 1'b0);
      xfer(32'h0001_E004, 1'b0, 32'h0, 4'h0, 3'd0, TB_TIMEOUT + 5, 32'h2468_ACE0, 1'b0);
      hang_and_reset(32'h000F_F000, 5);
`else
      hang_and_reset(32'h000F_F000, 1000);
`endif
      xfer(32'h000C_0004, 1'b0, 32'h0, 4'h0, 3'd0, 0, 32'hA5A5_0F0F, 1'b0);

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            a = $urandom & 32'h000F_FFFC;
         end else begin
            k = $urandom_range(0, NSLV - 1);
            a = map_base[k] + (32'($urandom_range(0, 1023)) << 2);
         end
         xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)), $urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 2));
      end

      idle(3);
      repeat (5) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_slv_switch.md
# apb_slv_switch

Parametrised APB switch connecting one upstream APB master port (from the AXI-to-APB bridge) to NSLV downstream APB slaves selected by a configurable address map. It is the general successor of the fixed Bus[1] slave map: slave count and map are parameters. It adds registered decode, an error response for unmapped addresses, and an optional per-access timeout. It sits between the system bridge and peripheral slaves such as UART, PRCI, DMI, GPIO, DDR management, PCIE and PnP.

## Interface
Parameters:
- NSLV, 7, number of downstream slaves (1..16)
- MAP, mapinfo_type array [0:NSLV-1], per-slave {addr_start, addr_end}; addr_end exclusive; default is the Bus[1] 4 KB map
- TIMEOUT_CYCLES, 1023, ACCESS-phase cycles before forced error (used only with the macro); counter width $clog2(TIMEOUT_CYCLES+1)

Ports:
- i_clk  in  1  clock, all logic rising edge
- i_nrst  in  1  reset, asynchronous, active-low
- i_apbi  in  apb_in_type  upstream request (paddr, psel, penable, pwrite, pwdata, pstrb, pprot)
- o_apbo  out  apb_out_type  upstream response (pready, prdata[31:0], pslverr)
- o_apbi  out  apb_in_type [0:NSLV-1]  downstream requests
- i_apbo  in  apb_out_type [0:NSLV-1]  downstream responses
- o_sel_idx  out  $clog2(NSLV+1)  index of active slave; NSLV when idle or unmapped (debug)

## Operation
- States: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- IDLE: on i_apbi.psel=1, latch paddr, pwrite, pwdata, pstrb and pprot.
  - Decode: slave k hits if MAP[k].addr_start <= {32'h0,paddr} < MAP[k].addr_end. Lowest index wins on overlap.
  - Hit -> SETUP, sel_idx=k. No hit -> RESP with err=1, rdata=0.
- SETUP: drive o_apbi[sel_idx] with psel=1, penable=0 and the latched fields -> ACCESS.
- ACCESS: o_apbi[sel_idx] psel=1, penable=1.
  - On i_apbo[sel_idx].pready=1: latch prdata and pslverr -> RESP.
  - All other slaves see psel=0, penable=0, and their paddr/pwdata are driven from the latched values.
- RESP: o_apbo.pready=1 for exactly one cycle with the latched prdata and pslverr -> IDLE. sel_idx returns to NSLV.
- Upstream pready is 0 in every state except RESP. Upstream request fields are ignored outside IDLE; the master holds them per APB.
- Requests arriving in the IDLE cycle right after RESP are accepted. Back-to-back transfers need no dead cycle beyond RESP.
- Non-selected slaves never see psel=1. pready and prdata from non-selected slaves are ignored.
- Reset asserted mid-transfer: all state is dropped immediately and every output returns to its reset value. Upstream must restart the transfer.

## Timing
- Reset values: o_apbo.pready=0, prdata=0, pslverr=0; all o_apbi fields 0; o_sel_idx=NSLV.
- Mapped access, slave ready at its first ACCESS cycle:
  - cycle 0: upstream psel seen in IDLE
  - cycle 1: SETUP
  - cycle 2: ACCESS, slave pready
  - cycle 3: upstream pready
  - Upstream latency = 3 + slave wait states.
- Unmapped access: upstream pready with pslverr=1 at cycle 1.
- All outputs are registered. No combinational path from i_apbo or i_apbi to any output.

## Configuration
- APB_SLV_SWITCH_TIMEOUT_EN defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle without pready.
  - When it reaches TIMEOUT_CYCLES: RESP with pslverr=1 and prdata=32'hFFFFFFFF. The downstream psel drops in the RESP cycle.
  - A slave pready arriving in the same cycle as the limit wins: normal response is returned.
- Undefined: no counter exists and ACCESS waits indefinitely for the slave.

## Test plan
- Read with NSLV=7, paddr=0x00012004, slave 1 returns prdata=0xCAFE0001 with zero wait states -> only o_apbi[1].psel asserts; upstream pready at cycle 3 with prdata=0xCAFE0001, pslverr=0.
- Write to 0x00060010, pwdata=0x5A5A5A5A, pstrb=4'hF, slave 3 inserts 4 wait states -> slave 3 sees the exact data and strobe; upstream pready at cycle 7; no other psel toggles.
- Access to unmapped 0x00020000 -> upstream pready at cycle 1 with pslverr=1, prdata=0; no downstream psel.
- Boundary addresses 0x00010FFC and 0x00011000 -> first selects slave 0; second is unmapped (exclusive end).
- With the macro and TIMEOUT_CYCLES=15, slave never ready -> pslverr=1, prdata=0xFFFFFFFF, after 15 ACCESS cycles. Without the macro -> still waiting after 1000 cycles.
- i_nrst low for 1 cycle during ACCESS -> all outputs reach reset values asynchronously; the next request completes normally.
